frame_reader: RTL and testbench



---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_timing.sv | 48 ++++
 rtl/frame_reader.sv | 82 ++++++++
 tb/tb_frame_reader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, counter types and RGB332 expansion shared by the scan-out path
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_ADDR_W = 19;
  typedef logic [9:0] hcnt_t;
  typedef logic [9:0] vcnt_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;
  function automatic rgb24_t rgb332_expand(input logic [7:0] q);
    rgb24_t c;
    c.r = {q[7:5], q[7:5], q[7:6]};
    c.g = {q[4:2], q[4:2], q[4:3]};
    c.b = {4{q[1:0]}};
    return c;
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-enable divider, h/v counters and raw sync/active/vblank/frame_start flags
// FRAME_READER_TEST_PATTERN_EN adds the colour-bar index output.
module vga_timing import vga_pkg::*; #(
  parameter int HA = H_ACTIVE, HFP = H_FP, HSW = H_SYNC, HBP = H_BP,
  parameter int VA = V_ACTIVE, VFP = V_FP, VSW = V_SYNC, VBP = V_BP
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en,
  output logic active,
  output logic hs,
  output logic vs,
  output logic vblank,
  output logic frame_start
`ifdef FRAME_READER_TEST_PATTERN_EN
  , output logic [2:0] bar
`endif
);
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  hcnt_t h;
  vcnt_t v;
  logic h_last, v_last;
  assign h_last = h == hcnt_t'(HT - 1);
  assign v_last = v == vcnt_t'(VT - 1);
  assign active = h < hcnt_t'(HA) && v < vcnt_t'(VA);
  assign hs = !(h >= hcnt_t'(HA + HFP) && h < hcnt_t'(HA + HFP + HSW));
  assign vs = !(v >= vcnt_t'(VA + VFP) && v < vcnt_t'(VA + VFP + VSW));
`ifdef FRAME_READER_TEST_PATTERN_EN
  assign bar = 3'(h / 10'd80);
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pix_en <= 1'b0;
      h <= '0;
      v <= '0;
      vblank <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en <= !pix_en;
      vblank <= v >= vcnt_t'(VA);
      frame_start <= pix_en && h_last && v_last;
      if (pix_en) begin
        h <= h_last ? '0 : h + 1'b1;
        if (h_last) v <= v_last ? '0 : v + 1'b1;
      end
    end
endmodule

// File: rtl/frame_reader.sv
// frame_reader: VGA scan-out, frame-buffer read addressing and RGB332 expansion with a 2-pixel pin pipeline
// FRAME_READER_TEST_PATTERN_EN replaces RAM data with 8 vertical colour bars.
module frame_reader import vga_pkg::*; #(
  parameter int HA = H_ACTIVE, HFP = H_FP, HSW = H_SYNC, HBP = H_BP,
  parameter int VA = V_ACTIVE, VFP = V_FP, VSW = V_SYNC, VBP = V_BP,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [7:0]        fb_q,
  output logic [ADDR_W-1:0] fb_rdaddress,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic              vblank,
  output logic              frame_start
);
  logic pix_en, active, hs, vs, active1, hs1, vs1;
  logic [ADDR_W-1:0] addr;
  rgb24_t pix;
`ifdef FRAME_READER_TEST_PATTERN_EN
  logic [2:0] bar, bar1;
  assign pix = {{8{bar1[2]}}, {8{bar1[1]}}, {8{bar1[0]}}};
`else
  assign pix = rgb332_expand(fb_q);
`endif
  vga_timing #(
    .HA(HA), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VA(VA), .VFP(VFP), .VSW(VSW), .VBP(VBP)
  ) u_timing (
    .clk(Clk),
    .rst_n(Reset_n),
    .pix_en,
    .active,
    .hs,
    .vs,
    .vblank,
    .frame_start
`ifdef FRAME_READER_TEST_PATTERN_EN
    , .bar
`endif
  );
  assign VGA_CLK = pix_en;
  assign VGA_SYNC_N = 1'b0;
  // vblank was sampled on the idle half-pixel, so on pix_en edges it equals v >= VA
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      active1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      addr <= '0;
      fb_rdaddress <= '0;
      {VGA_R, VGA_G, VGA_B} <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_BLANK_N <= 1'b0;
`ifdef FRAME_READER_TEST_PATTERN_EN
      bar1 <= '0;
`endif
    end else if (pix_en) begin
      active1 <= active;
      hs1 <= hs;
      vs1 <= vs;
`ifdef FRAME_READER_TEST_PATTERN_EN
      bar1 <= bar;
`endif
      if (vblank) addr <= '0;
      else if (active) begin
        fb_rdaddress <= addr;
        addr <= addr + 1'b1;
      end
      {VGA_R, VGA_G, VGA_B} <= active1 ? pix : '0;
      VGA_HS <= hs1;
      VGA_VS <= vs1;
      VGA_BLANK_N <= active1;
    end
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: full-size instance checks line timing and pixels; a shrunken-timing instance checks whole frames
module tb_frame_reader;
  localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 2;
  localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB, SVT = SVA + SVF + SVS + SVB, SFR = SHT * SVT;
  localparam logic [49:0] RST = {7'b0110000, 43'd0};
`ifdef FRAME_READER_TEST_PATTERN_EN
  localparam logic [23:0] PIX51 = 24'h000000;
`else
  localparam logic [23:0] PIX51 = 24'h922455;
`endif
  logic Clk = 1'b0;
  logic rst_b = 1'b0, rst_s = 1'b0;
  logic [7:0] q_b, q_s, r_b, g_b, b_b, r_s, g_s, b_s;
  logic [18:0] a_b, a_s;
  logic ck_b, hs_b, vs_b, bl_b, sy_b, vb_b, fs_b;
  logic ck_s, hs_s, vs_s, bl_s, sy_s, vb_s, fs_s;
  logic [7:0] mem [128];
  logic ff_mode = 1'b0;
  int checks = 0, passed = 0, shown = 0;
  wire [49:0] obs_b = {ck_b, hs_b, vs_b, bl_b, sy_b, vb_b, fs_b, r_b, g_b, b_b, a_b};
  wire [49:0] obs_s = {ck_s, hs_s, vs_s, bl_s, sy_s, vb_s, fs_s, r_s, g_s, b_s, a_s};

  always #10 Clk = ~Clk;
  always @(posedge Clk) begin
    q_b <= a_b[7:0];
    q_s <= ff_mode ? 8'hFF : mem[a_s[6:0]];
  end

  frame_reader dut_b (
    .Clk(Clk), .Reset_n(rst_b), .fb_q(q_b), .fb_rdaddress(a_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_CLK(ck_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sy_b), .vblank(vb_b), .frame_start(fs_b)
  );
  frame_reader #(
    .HA(SHA), .HFP(SHF), .HSW(SHS), .HBP(SHB), .VA(SVA), .VFP(SVF), .VSW(SVS), .VBP(SVB)
  ) dut_s (
    .Clk(Clk), .Reset_n(rst_s), .fb_q(q_s), .fb_rdaddress(a_s),
    .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s), .VGA_CLK(ck_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
    .VGA_BLANK_N(bl_s), .VGA_SYNC_N(sy_s), .vblank(vb_s), .frame_start(fs_s)
  );

  function automatic logic [23:0] color(input int hh, input logic [7:0] q);
    logic [2:0] k, r, g;
    k = 3'(hh / 80);
    r = q[7:5];
    g = q[4:2];
`ifdef FRAME_READER_TEST_PATTERN_EN
    return {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
`else
    return {r, r, r[2:1], g, g, g[2:1], {4{q[1:0]}}};
`endif
  endfunction

  // pins after Clk edge k show pixel k/2-2; full-size frame only needs the first lines here
  function automatic logic [25:0] exp_big(input int k);
    int n, hh, vv;
    logic act;
    n = k / 2 - 2;
    if (n < 0) return {2'b10, 24'h0};
    hh = n % 800;
    vv = n / 800;
    act = hh < 640 && vv < 480;
    return {!(hh >= 656 && hh < 752), act, act ? color(hh, 8'(vv * 640 + hh)) : 24'h0};
  endfunction

  function automatic logic [49:0] exp_small(input int k);
    int n, m, hh, vv;
    logic hs, vs, act, vb, fs;
    logic [23:0] rgb;
    logic [18:0] ad;
    n = k / 2 - 2;
    hs = 1'b1; vs = 1'b1; act = 1'b0; rgb = 24'h0;
    if (n >= 0) begin
      hh = n % SHT;
      vv = (n / SHT) % SVT;
      act = hh < SHA && vv < SVA;
      hs = !(hh >= SHA + SHF && hh < SHA + SHF + SHS);
      vs = !(vv >= SVA + SVF && vv < SVA + SVF + SVS);
      if (act) rgb = color(hh, ff_mode ? 8'hFF : mem[vv * SHA + hh]);
    end
    m = k / 2 - 1;
    ad = 19'd0;
    if (m >= 0) begin
      hh = m % SHT;
      vv = (m / SHT) % SVT;
      ad = 19'(vv >= SVA ? SHA * SVA - 1 : hh < SHA ? vv * SHA + hh : vv * SHA + SHA - 1);
    end
    vb = k >= 1 && (((k - 1) / 2 / SHT) % SVT) >= SVA;
    fs = k >= 2 && k % 2 == 0 && (k / 2) % SFR == 0;
    return {1'(k % 2), hs, vs, act, 1'b0, vb, fs, rgb, ad};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    #1;
    checks++;
    if (obs_b !== RST) $display("FAIL reset_big got %h want %h", obs_b, RST); else passed++;
    checks++;
    if (obs_s !== RST) $display("FAIL reset_small got %h want %h", obs_s, RST); else passed++;
  endtask

  task automatic test_big();
    int f1 = -1, f2 = -1, r1 = -1;
    logic ph = 1'b1;
    logic [25:0] e;
    @(negedge Clk);
    rst_b = 1'b1;
    #1;
    for (int k = 0; k <= 3400; k++) begin
      if (k > 0) begin @(negedge Clk); #1; end
      e = exp_big(k);
      checks++;
      if ({hs_b, bl_b, r_b, g_b, b_b} !== e) begin
        if (shown++ < 20) $display("FAIL big_pixel k=%0d got %h want %h", k, {hs_b, bl_b, r_b, g_b, b_b}, e);
      end else passed++;
      if (ph && !hs_b) begin if (f1 < 0) f1 = k; else if (f2 < 0) f2 = k; end
      if (!ph && hs_b && r1 < 0) r1 = k;
      ph = hs_b;
      if (k == 1614) begin
        checks++;
        if ({bl_b, r_b, g_b, b_b} !== {1'b1, PIX51}) $display("FAIL pixel_5_1 got %h want %h", {bl_b, r_b, g_b, b_b}, {1'b1, PIX51}); else passed++;
      end
`ifdef FRAME_READER_TEST_PATTERN_EN
      if (k == 84 || k == 1204) begin
        checks++;
        if ({r_b, g_b, b_b} !== (k == 84 ? 24'h000000 : 24'hFFFFFF)) $display("FAIL bar k=%0d got %h", k, {r_b, g_b, b_b}); else passed++;
      end
`endif
    end
    checks++;
    if (f2 - f1 != 1600) $display("FAIL hs_period got %0d want 1600", f2 - f1); else passed++;
    checks++;
    if (r1 - f1 != 192) $display("FAIL hs_low got %0d want 192", r1 - f1); else passed++;
  endtask

  task automatic test_frame();
    int fs1 = -1, fs2 = -1, vsl = 0, vbh = 0;
    logic [49:0] e;
    rst_s = 1'b0;
    ff_mode = 1'b0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    #3;
    @(negedge Clk);
    rst_s = 1'b1;
    #1;
    for (int k = 0; k <= 1000; k++) begin
      if (k > 0) begin @(negedge Clk); #1; end
      e = exp_small(k);
      checks++;
      if (obs_s !== e) begin
        if (shown++ < 20) $display("FAIL frame k=%0d got %h want %h", k, obs_s, e);
      end else passed++;
      if (fs_s) begin if (fs1 < 0) fs1 = k; else if (fs2 < 0) fs2 = k; end
      if (fs1 >= 0 && fs2 < 0) begin vsl += int'(!vs_s); vbh += int'(vb_s); end
      if (k == 480) begin
        checks++;
        if (a_s !== 19'(SHA * SVA - 1)) $display("FAIL last_addr got %0d want %0d", a_s, SHA * SVA - 1); else passed++;
      end
      if (k == 482) begin
        checks++;
        if (a_s !== 19'd0) $display("FAIL first_addr got %0d want 0", a_s); else passed++;
      end
    end
    checks++;
    if (fs2 - fs1 != 2 * SFR) $display("FAIL frame_period got %0d want %0d", fs2 - fs1, 2 * SFR); else passed++;
    checks++;
    if (vsl != 2 * SVS * SHT) $display("FAIL vs_low got %0d want %0d", vsl, 2 * SVS * SHT); else passed++;
    checks++;
    if (vbh != 2 * (SVT - SVA) * SHT) $display("FAIL vblank_len got %0d want %0d", vbh, 2 * (SVT - SVA) * SHT); else passed++;
  endtask

  task automatic test_blank_ff();
    int viol = 0;
    logic [49:0] e;
    rst_s = 1'b0;
    ff_mode = 1'b1;
    #3;
    @(negedge Clk);
    rst_s = 1'b1;
    #1;
    for (int k = 0; k <= 520; k++) begin
      if (k > 0) begin @(negedge Clk); #1; end
      e = exp_small(k);
      checks++;
      if (obs_s !== e) begin
        if (shown++ < 20) $display("FAIL blank_ff k=%0d got %h want %h", k, obs_s, e);
      end else passed++;
      if (!bl_s && {r_s, g_s, b_s} !== 24'h0) viol++;
    end
    checks++;
    if (viol != 0) $display("FAIL blank_rgb got %0d nonzero want 0", viol); else passed++;
    ff_mode = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [49:0] e;
    rst_s = 1'b0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    #3;
    @(negedge Clk);
    rst_s = 1'b1;
    #1;
    for (int k = 0; k <= 2 * (3 * SHT + 10); k++) begin
      if (k > 0) begin @(negedge Clk); #1; end
      e = exp_small(k);
      checks++;
      if (obs_s !== e) begin
        if (shown++ < 20) $display("FAIL pre_reset k=%0d got %h want %h", k, obs_s, e);
      end else passed++;
    end
    rst_s = 1'b0;
    #2;
    checks++;
    if (obs_s !== RST) $display("FAIL async_reset got %h want %h", obs_s, RST); else passed++;
    @(negedge Clk);
    rst_s = 1'b1;
    #1;
    for (int k = 0; k <= 300; k++) begin
      if (k > 0) begin @(negedge Clk); #1; end
      e = exp_small(k);
      checks++;
      if (obs_s !== e) begin
        if (shown++ < 20) $display("FAIL post_reset k=%0d got %h want %h", k, obs_s, e);
      end else passed++;
      if (k == 4) begin
        checks++;
        if (a_s !== 19'd1) $display("FAIL restart_addr got %0d want 1", a_s); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_big();
    test_frame();
    test_blank_ff();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
